// File: rtl/dac_spi_driver_pkg.sv
// Shared definitions for the DAC SPI driver: state encoding, frame width, default command.
// The LDAC state is present only when DAC_SPI_LDAC_EN is defined.
package dac_spi_pkg;

  localparam int FRAME_W = 16;
  localparam logic [3:0] DEFAULT_CTRL = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_HOLD     = 3'd4,
    ST_GAP      = 3'd5
`ifdef DAC_SPI_LDAC_EN
    , ST_LDAC   = 3'd6
`endif
  } dac_spi_state_e;

  // Frame layout: command nibble, DAC code, four don't-care zero bits.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0] ctrl,
                                                     input logic [7:0] code);
    return {ctrl, code, 4'b0000};
  endfunction

endpackage

// File: rtl/dac_spi_driver_up_counter.sv
// Generic synchronous up counter with clear and enable; clear wins over enable.
module up_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dac_spi_driver.sv
// Serialises the pmic_core DAC code into 16-bit SPI frames whenever it changes.
// Optional DAC_SPI_LDAC_EN adds an ldac_n load strobe after each frame.
module dac_spi_driver
  import dac_spi_pkg::*;
#(
  parameter int         CLK_DIV = 2,
  parameter logic [3:0] CTRL    = DEFAULT_CTRL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dac_code,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic [2:0] state_dbg
`ifdef DAC_SPI_LDAC_EN
  ,
  output logic       ldac_n
`endif
);

  dac_spi_state_e       state;
  dac_spi_state_e       next_state;
  logic [7:0]           last_code;
  logic                 pending_init;
  logic [FRAME_W-1:0]   shift_reg;
  logic [3:0]           bit_idx;
  logic [7:0]           count;
  logic                 phase_done;
  logic                 start;
  logic                 cnt_clear;
  logic                 cnt_en;

  assign phase_done = (count == 8'(CLK_DIV - 1));
  assign start      = (state == ST_IDLE) && ((dac_code != last_code) || pending_init);
  assign cnt_clear  = (next_state != state);
  assign cnt_en     = (state != ST_IDLE);
  assign state_dbg  = state;

  up_counter #(.W(8)) u_phase_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (start) next_state = ST_SETUP;
      ST_SETUP:    if (phase_done) next_state = ST_SHIFT_HI;
      ST_SHIFT_LO: if (phase_done) next_state = ST_SHIFT_HI;
      ST_SHIFT_HI: if (phase_done) next_state = (bit_idx == 4'd0) ? ST_HOLD : ST_SHIFT_LO;
      ST_HOLD:     if (phase_done) next_state = ST_GAP;
`ifdef DAC_SPI_LDAC_EN
      ST_GAP:      if (phase_done) next_state = ST_LDAC;
      ST_LDAC:     if (phase_done) next_state = ST_IDLE;
`else
      ST_GAP:      if (phase_done) next_state = ST_IDLE;
`endif
      default:     next_state = ST_IDLE;
    endcase
  end

  // The code is sampled only in IDLE, so updates during a frame collapse to the latest value.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_code    <= 8'h00;
      pending_init <= 1'b1;
      shift_reg    <= '0;
      bit_idx      <= 4'd0;
    end else if (start) begin
      last_code    <= dac_code;
      pending_init <= 1'b0;
      shift_reg    <= build_frame(CTRL, dac_code);
      bit_idx      <= 4'(FRAME_W - 1);
    end else if (state == ST_SHIFT_HI && phase_done) begin
      shift_reg    <= {shift_reg[FRAME_W-2:0], 1'b0};
      bit_idx      <= bit_idx - 4'd1;
    end
  end

  always_comb begin
    sclk = 1'b0;
    mosi = 1'b0;
    cs_n = 1'b1;
    busy = (state != ST_IDLE);
    case (state)
      ST_SETUP, ST_SHIFT_LO: begin
        cs_n = 1'b0;
        mosi = shift_reg[FRAME_W-1];
      end
      ST_SHIFT_HI: begin
        cs_n = 1'b0;
        sclk = 1'b1;
        mosi = shift_reg[FRAME_W-1];
      end
      ST_HOLD: cs_n = 1'b0;
      default: ;
    endcase
  end

`ifdef DAC_SPI_LDAC_EN
  assign ldac_n = (state != ST_LDAC);
`endif

endmodule

// File: tb/tb_dac_spi_driver.sv
// Directed bench for dac_spi_driver; build with DAC_SPI_LDAC_EN to cover the load strobe.
module tb_dac_spi_driver;

`ifdef DAC_SPI_LDAC_EN
  localparam int CD = 3;
`else
  localparam int CD = 2;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dac_code;
  logic       sclk, mosi, cs_n, busy;
  logic [2:0] state_dbg;
`ifdef DAC_SPI_LDAC_EN
  logic       ldac_n;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dac_spi_driver #(.CLK_DIV(CD), .CTRL(4'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .dac_code  (dac_code),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .busy      (busy),
    .state_dbg (state_dbg)
`ifdef DAC_SPI_LDAC_EN
    ,
    .ldac_n    (ldac_n)
`endif
  );

  // Called on a falling edge; returns on the first falling edge with cs_n high after a frame.
  task automatic capture_frame(output logic [15:0] data, output int cs_low, output int pulses,
                               output int bad_width, output int idle_before, output bit timeout);
    int hi;
    logic prev_sclk;
    data = '0; cs_low = 0; pulses = 0; bad_width = 0; idle_before = 0; timeout = 0;
    hi = 0; prev_sclk = 1'b0;
    while (cs_n !== 1'b0 && idle_before < 2000) begin
      idle_before++;
      @(negedge clk);
    end
    if (cs_n !== 1'b0) begin
      timeout = 1;
      return;
    end
    while (cs_n === 1'b0 && cs_low < 5000) begin
      cs_low++;
      if (sclk === 1'b1) begin
        if (prev_sclk !== 1'b1) begin
          pulses++;
          data = {data[14:0], mosi};
        end
        hi++;
      end else if (prev_sclk === 1'b1) begin
        if (hi != CD) bad_width++;
        hi = 0;
      end
      prev_sclk = sclk;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dac_code = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    n_checks++;
    if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    n_checks++;
    if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
`ifdef DAC_SPI_LDAC_EN
    n_checks++;
    if (ldac_n !== 1'b1) begin n_fail++; $display("FAIL reset_ldac_n: got %b expected 1", ldac_n); end
`endif
  endtask

  task automatic test_init_frame();
    logic [15:0] data;
    int cs_low, pulses, bad_w, idle_b, nb, exp_tail;
    bit to;
    reset = 1'b0;
    capture_frame(data, cs_low, pulses, bad_w, idle_b, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL init_timeout: no frame after reset release"); end
    n_checks++;
    if (data !== 16'h0000) begin n_fail++; $display("FAIL init_data: got %h expected 0000", data); end
    n_checks++;
    if (cs_low != 33 * CD) begin n_fail++; $display("FAIL init_cs_low: got %0d expected %0d", cs_low, 33 * CD); end
    nb = 0;
    while (busy === 1'b1 && nb < 1000) begin
      nb++;
      @(negedge clk);
    end
`ifdef DAC_SPI_LDAC_EN
    exp_tail = 2 * CD;
`else
    exp_tail = CD;
`endif
    n_checks++;
    if (nb != exp_tail) begin n_fail++; $display("FAIL init_busy_tail: got %0d expected %0d", nb, exp_tail); end
  endtask

  task automatic test_a5();
    logic [15:0] data;
    int cs_low, pulses, bad_w, idle_b;
    bit to;
    dac_code = 8'hA5;
    capture_frame(data, cs_low, pulses, bad_w, idle_b, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL a5_timeout: no frame"); end
    n_checks++;
    if (data !== 16'h0A50) begin n_fail++; $display("FAIL a5_data: got %h expected 0a50", data); end
    n_checks++;
    if (pulses != 16) begin n_fail++; $display("FAIL a5_pulses: got %0d expected 16", pulses); end
    n_checks++;
    if (bad_w != 0) begin n_fail++; $display("FAIL a5_width: got %0d bad pulses expected 0", bad_w); end
    repeat (4 * CD) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] d1, d2, d3;
    int l1, p1, b1, i1, l2, p2, b2, i2, l3, p3, b3, i3;
    bit t1, t2, t3;
    dac_code = 8'h10;
    fork
      capture_frame(d1, l1, p1, b1, i1, t1);
      begin
        repeat (20) @(negedge clk);
        dac_code = 8'h20;
        repeat (20) @(negedge clk);
        dac_code = 8'h30;
      end
    join
    capture_frame(d2, l2, p2, b2, i2, t2);
    n_checks++;
    if (t1 || d1 !== 16'h0100) begin n_fail++; $display("FAIL b2b_frame1: got %h expected 0100", d1); end
    n_checks++;
    if (t2 || d2 !== 16'h0300) begin n_fail++; $display("FAIL b2b_frame2: got %h expected 0300", d2); end
    n_checks++;
    if (i2 < CD) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles expected >= %0d", i2, CD); end
    n_checks++;
    if (l2 != 33 * CD) begin n_fail++; $display("FAIL b2b_cs_low: got %0d expected %0d", l2, 33 * CD); end
    capture_frame(d3, l3, p3, b3, i3, t3);
    n_checks++;
    if (!t3) begin n_fail++; $display("FAIL b2b_extra_frame: got frame %h expected none", d3); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] data;
    int cs_low, pulses, bad_w, idle_b, rises, n;
    bit to;
    logic prev;
    dac_code = 8'h77;
    rises = 0; n = 0; prev = 1'b0;
    while (rises < 5 && n < 2000) begin
      @(negedge clk);
      if (sclk === 1'b1 && prev !== 1'b1) rises++;
      prev = sclk;
      n++;
    end
    n_checks++;
    if (rises != 5) begin n_fail++; $display("FAIL midrst_rises: got %0d expected 5", rises); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cs_n !== 1'b1) begin n_fail++; $display("FAIL midrst_cs_n: got %b expected 1", cs_n); end
    n_checks++;
    if (sclk !== 1'b0) begin n_fail++; $display("FAIL midrst_sclk: got %b expected 0", sclk); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    reset = 1'b0;
    capture_frame(data, cs_low, pulses, bad_w, idle_b, to);
    n_checks++;
    if (to || data !== 16'h0770) begin n_fail++; $display("FAIL midrst_refire: got %h expected 0770", data); end
    n_checks++;
    if (pulses != 16 || cs_low != 33 * CD) begin
      n_fail++;
      $display("FAIL midrst_full: got %0d pulses %0d cs_low expected 16 %0d", pulses, cs_low, 33 * CD);
    end
  endtask

  task automatic test_no_retrigger();
    int busy_cycles, cs_cycles;
    repeat (4 * CD) @(negedge clk);
    busy_cycles = 0; cs_cycles = 0;
    repeat (500) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_cycles++;
      if (cs_n !== 1'b1) cs_cycles++;
    end
    n_checks++;
    if (busy_cycles != 0) begin n_fail++; $display("FAIL idle_busy: got %0d cycles expected 0", busy_cycles); end
    n_checks++;
    if (cs_cycles != 0) begin n_fail++; $display("FAIL idle_cs_n: got %0d cycles expected 0", cs_cycles); end
  endtask

`ifdef DAC_SPI_LDAC_EN
  task automatic test_ldac();
    logic [15:0] data;
    int cs_low, pulses, bad_w, idle_b, delay, width;
    bit to;
    dac_code = 8'h3C;
    capture_frame(data, cs_low, pulses, bad_w, idle_b, to);
    n_checks++;
    if (to || data !== 16'h03C0) begin n_fail++; $display("FAIL ldac_frame: got %h expected 03c0", data); end
    delay = 0;
    while (ldac_n === 1'b1 && delay < 100) begin
      delay++;
      @(negedge clk);
    end
    n_checks++;
    if (delay != CD) begin n_fail++; $display("FAIL ldac_delay: got %0d expected %0d", delay, CD); end
    width = 0;
    while (ldac_n === 1'b0 && width < 100) begin
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL ldac_busy_low: got %b expected 1", busy); end
      width++;
      @(negedge clk);
    end
    n_checks++;
    if (width != CD) begin n_fail++; $display("FAIL ldac_width: got %0d expected %0d", width, CD); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ldac_busy_end: got %b expected 0", busy); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    dac_code = 8'h00;
    @(negedge clk);
    test_reset();
    test_init_frame();
    test_a5();
    test_back_to_back();
    test_reset_mid_frame();
    test_no_retrigger();
`ifdef DAC_SPI_LDAC_EN
    test_ldac();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_spi_driver.md
DAC_SPI_DRIVER -- requirements
Module: dac_spi_driver

Interface
REQ-001 Parameter CLK_DIV, default 2, gives the sclk half-period in clk cycles; legal range 1..255.
REQ-002 Parameter CTRL, default 4'h0, gives the 4-bit DAC command field placed in frame bits [15:12].
REQ-003 clk  input  1  clock; all logic is posedge clk.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 dac_code  input  8  requested DAC code, driven by the pmic_core dac_out register.
REQ-006 sclk  output  1  serial clock to the DAC; idles low.
REQ-007 mosi  output  1  serial data to the DAC, MSB first.
REQ-008 cs_n  output  1  DAC frame select, active-low.
REQ-009 busy  output  1  high while a frame is in progress, including the gap.
REQ-010 ldac_n  output  1  DAC load strobe, active-low; present only with DAC_SPI_LDAC_EN.

Function
REQ-011 The frame SHALL be 16 bits {CTRL, code[7:0], 4'b0000}, shifted MSB first.
REQ-012 States SHALL be IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP, and LDAC (LDAC only with the macro).
REQ-013 In IDLE, when dac_code != last_code or pending_init=1, the block SHALL:
- latch dac_code into last_code and the shift register;
- clear pending_init;
- enter SETUP on the next cycle.
REQ-014 SETUP and SHIFT_LO SHALL each last CLK_DIV cycles with sclk=0 and mosi = the current frame bit; cs_n=0 from the first SETUP cycle.
REQ-015 SHIFT_HI SHALL last CLK_DIV cycles with sclk=1 and mosi held stable.
- After SHIFT_HI the frame advances to the next bit and returns to SHIFT_LO.
- After the 16th SHIFT_HI the block goes to HOLD.
REQ-016 Sequence: SETUP is bit 15's low phase; each of the 16 bits gets one low phase and one SHIFT_HI.
REQ-017 HOLD SHALL last CLK_DIV cycles with sclk=0 and cs_n=0; cs_n SHALL be low for exactly 33*CLK_DIV cycles per frame.
REQ-018 GAP SHALL last CLK_DIV cycles with cs_n=1, sclk=0, mosi=0, then go to LDAC (with macro) or IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 Changes on dac_code while busy=1 SHALL NOT affect the frame in flight.
- The value present on return to IDLE is compared against last_code.
- Only the latest value is sent; intermediate values are dropped.
REQ-021 Back-to-back frames SHALL be separated by at least CLK_DIV cycles of cs_n=1.
REQ-022 Phase timing SHALL use an 8-bit counter.
- The counter clears on every state change.
- The phase ends when count == CLK_DIV-1.

Reset
REQ-023 On reset the outputs SHALL take these values on the next edge: cs_n=1, sclk=0, mosi=0, busy=0, ldac_n=1.
REQ-024 On reset the internal state SHALL be: state=IDLE, last_code=0, pending_init=1.
REQ-025 A reset mid-frame SHALL abort the frame immediately (cs_n=1 next cycle), discard it, and send a full frame after reset release.

Configuration
REQ-026 With DAC_SPI_LDAC_EN defined, the LDAC state SHALL:
- follow GAP;
- drive ldac_n=0 for CLK_DIV cycles with busy=1;
- then return to IDLE.
REQ-027 Without DAC_SPI_LDAC_EN, the ldac_n port and the LDAC state SHALL NOT exist, and GAP SHALL return directly to IDLE.

Structure
REQ-028 Package dac_spi_pkg SHALL hold:
- the state encoding constants;
- FRAME_W=16;
- the default CTRL value.
REQ-029 The phase counter SHALL be an instance of the existing up_counter; no other sub-module is needed.

Verification
REQ-030 Reset then release with dac_code=8'h00, CLK_DIV=2: one frame 16'h0000; cs_n low for 66 cycles; busy falls 2 cycles after cs_n rises.
REQ-031 With dac_code=8'hA5 in IDLE: mosi sampled on the 16 sclk rising edges = 16'h0A50; exactly 16 sclk pulses, each high for 2 clk.
REQ-032 Stimulus: dac_code=8'h10, then 8'h20 then 8'h30 during that frame. Response: exactly two frames, carrying 8'h10 and 8'h30; the frames are separated by at least 2 cycles of cs_n=1.
REQ-033 Assert reset after the 5th sclk rise of a frame: cs_n=1 and sclk=0 the next cycle; after release a full frame of the current code is sent.
REQ-034 Stimulus: dac_code held constant after a frame for 500 cycles. Response: no further frame; busy stays 0.
REQ-035 With DAC_SPI_LDAC_EN, CLK_DIV=3: ldac_n pulses low for 3 cycles starting 3 cycles after cs_n rises; busy drops the cycle after ldac_n returns high.
